l2_port_arbiter: RTL and testbench
==================================

# l2_port_arbiter

- Shares one lower-level cache/memory port between two upper-level requesters, e.g. split instruction and data L1 caches feeding a single L2.
- Arbitrates round-robin and latches the winner's address, write flag and write data.
- Drives the lower level with the level-held `enable` / `fetchComplete` handshake, then returns the block and a one-cycle done pulse to the winner.
- Includes a per-transaction timeout so a stalled lower level cannot hang a requester.

## Interface
Parameters:
- ADDR_LENGTH, 10, address width in bits
- BLOCK_SIZE, 32, block width in bits (lower data in and out)
- TIMEOUT, 255, maximum cycles in ISSUE before abort; 0 disables the timeout

Ports (clock and reset first):
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- req0, req1  in  1 each  level request; held until the matching done pulse
- addr0, addr1  in  ADDR_LENGTH each  request address, sampled at grant
- write0, write1  in  1 each  1 = write, 0 = read; sampled at grant
- wdata0, wdata1  in  BLOCK_SIZE each  write data, sampled at grant
- done0, done1  out  1 each  one-cycle completion pulse to the owner
- rdata  out  BLOCK_SIZE  returned block; valid only while done0 or done1 is high
- err  out  1  high with done when the transaction timed out
- owner  out  1  index of the current or last granted requester
- lower_enable  out  1  request to lower level, held high through ISSUE
- lower_addr  out  ADDR_LENGTH  latched address
- lower_write  out  1  latched write flag
- lower_data_out  out  BLOCK_SIZE  latched write data
- lower_fetchComplete  in  1  lower level done; sampled only in ISSUE
- lower_data_in  in  BLOCK_SIZE  lower read data; captured when lower_fetchComplete is sampled high

## Operation
- FSM states and their outputs:
  - IDLE: lower_enable=0, done=0.
  - ISSUE: lower_enable=1.
  - RESP: lower_enable=0, done(owner)=1.
- IDLE:
  - If any req is high, pick the winner, latch its addr, write and wdata into the lower_* registers, set owner, clear the timeout counter, and go to ISSUE.
  - Otherwise stay in IDLE.
- Round-robin:
  - If only one req is high, it wins.
  - If both are high, the requester not equal to last_grant wins.
  - last_grant updates on every grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
- ISSUE:
  - lower_fetchComplete=1: capture lower_data_in into rdata (reads and writes alike), set err=0, go to RESP.
  - Else if TIMEOUT≠0 and the counter equals TIMEOUT-1: set rdata=0, set err=1, go to RESP.
  - Else increment the counter.
  - Counter width is $clog2(TIMEOUT+1), with a minimum of 1.
- RESP: pulse done for exactly one cycle, then go to IDLE unconditionally.
  - Dropping lower_enable for this cycle is required: the lower cache clears its state on ~enable.
- Requester contract:
  - Deassert req at the edge on which done is sampled high.
  - A req still high in IDLE is treated as a new request.
- A req that drops while in ISSUE is ignored: the transaction completes and done still pulses.
- Requests arriving in ISSUE or RESP wait; at most one transaction is outstanding.
- Reset (async, low), including mid-transaction:
  - State goes to IDLE.
  - All outputs go to 0: lower_enable, done0/1, err, rdata, lower_addr, lower_write, lower_data_out and owner.
  - last_grant goes to 1.
  - A lower transaction aborted by reset is not resumed.

## Timing
- All state and outputs are registered; there are no combinational paths from inputs to outputs.
- Cycle numbering (cycle 0 = first IDLE cycle in which req is sampled high):
  - ISSUE occupies cycles 1..k.
  - lower_fetchComplete is sampled high at the end of cycle k.
  - RESP is cycle k+1, with done and rdata valid.
  - IDLE is cycle k+2.
- Minimum request-to-done latency is 2 cycles, when lower_fetchComplete is high in the first ISSUE cycle.
- Back-to-back transactions: the next grant is decided in IDLE cycle k+2, so the next lower_enable rises at cycle k+3.
  - This gives at least 2 cycles of lower_enable low between transactions.
- Timeout: the abort occurs at the end of the TIMEOUT-th ISSUE cycle; done and err rise in the next cycle.
- A lower_fetchComplete in the same cycle the timeout would fire wins: completion with err=0.

## Test plan
- Reset: hold reset=0 with req0=req1=1 -> all outputs 0 and state IDLE; release -> req0 granted first (owner=0, lower_enable=1 one cycle later).
- Single read: req0=1, addr0=10'h004, lower returns lower_fetchComplete=1 with lower_data_in=32'hDEADBEEF after 3 ISSUE cycles -> done0 one cycle with rdata=32'hDEADBEEF, err=0, lower_addr=10'h004.
- Contention: req0 and req1 held high continuously, requesters re-asserting after each done -> grants alternate 0,1,0,1, and lower_enable is low for at least 2 cycles between transactions.
- Write: req1=1, write1=1, wdata1=32'hFFFFFFFF -> lower_write=1, lower_data_out=32'hFFFFFFFF throughout ISSUE; done1 pulses after lower_fetchComplete.
- Timeout: TIMEOUT=8, lower never responds -> lower_enable high exactly 8 cycles, then done0=1, err=1, rdata=0; fetchComplete coincident with cycle 8 -> err=0.
- Reset mid-ISSUE: assert reset=0 while lower_enable=1 -> lower_enable drops immediately (async), no done pulse; after release a pending req1 is granted normally.

Source files
------------

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter sharing one lower cache/memory port between two requesters,
// with a level-held enable/fetchComplete handshake and a per-transaction timeout.
`timescale 1ns/1ps
module l2_port_arbiter #(
  parameter int ADDR_LENGTH = 10,
  parameter int BLOCK_SIZE  = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic [ADDR_LENGTH-1:0] addr0,
  input  logic [ADDR_LENGTH-1:0] addr1,
  input  logic                   write0,
  input  logic                   write1,
  input  logic [BLOCK_SIZE-1:0]  wdata0,
  input  logic [BLOCK_SIZE-1:0]  wdata1,
  output logic                   done0,
  output logic                   done1,
  output logic [BLOCK_SIZE-1:0]  rdata,
  output logic                   err,
  output logic                   owner,
  output logic                   lower_enable,
  output logic [ADDR_LENGTH-1:0] lower_addr,
  output logic                   lower_write,
  output logic [BLOCK_SIZE-1:0]  lower_data_out,
  input  logic                   lower_fetchComplete,
  input  logic [BLOCK_SIZE-1:0]  lower_data_in
);

  localparam int CW = (TIMEOUT == 0) ? 1 : (($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1));
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} stateT;

  stateT           state;
  stateT           nextState;
  logic            lastGrant;
  logic [CW-1:0]   timeoutCount;
  logic            grantReq;
  logic            grantIdx;
  logic            timedOut;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // On a tie the requester that did not win last time gets the port.
  always_comb begin
    nextState = state;
    grantReq  = 1'b0;
    grantIdx  = 1'b0;
    timedOut  = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grantReq  = 1'b1;
          grantIdx  = req1 && (!req0 || !lastGrant);
          nextState = ISSUE;
        end
      end
      ISSUE: begin
        if (lower_fetchComplete) begin
          nextState = RESP;
        end else if ((TIMEOUT != 0) && (timeoutCount == TMAX)) begin
          timedOut  = 1'b1;
          nextState = RESP;
        end
      end
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner          <= 1'b0;
      lastGrant      <= 1'b1;
      lower_addr     <= '0;
      lower_write    <= 1'b0;
      lower_data_out <= '0;
      rdata          <= '0;
      err            <= 1'b0;
      timeoutCount   <= '0;
    end else begin
      if (grantReq) begin
        owner          <= grantIdx;
        lastGrant      <= grantIdx;
        lower_addr     <= grantIdx ? addr1  : addr0;
        lower_write    <= grantIdx ? write1 : write0;
        lower_data_out <= grantIdx ? wdata1 : wdata0;
        timeoutCount   <= '0;
      end
      // A completion arriving on the timeout cycle takes priority over the abort.
      if (state == ISSUE) begin
        if (lower_fetchComplete) begin
          rdata <= lower_data_in;
          err   <= 1'b0;
        end else if (timedOut) begin
          rdata <= '0;
          err   <= 1'b1;
        end else begin
          timeoutCount <= timeoutCount + CW'(1);
        end
      end
      if (state == RESP) err <= 1'b0;
    end
  end

  assign lower_enable = (state == ISSUE);
  assign done0        = (state == RESP) && !owner;
  assign done1        = (state == RESP) && owner;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Scoreboard bench for l2_port_arbiter: directed requests, a scripted lower level,
// and a monitor that checks every ISSUE cycle and every done pulse against the queue.
`timescale 1ns/1ps
module tb_l2_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [9:0]  addr0, addr1;
  logic        write0, write1;
  logic [31:0] wdata0, wdata1;
  logic        done0, done1;
  logic [31:0] rdata;
  logic        err;
  logic        owner;
  logic        lower_enable;
  logic [9:0]  lower_addr;
  logic        lower_write;
  logic [31:0] lower_data_out;
  logic        lower_fetchComplete;
  logic [31:0] lower_data_in;

  int vectors     = 0;
  int miscompares = 0;

  int          lowerDelay = -1;
  logic [31:0] lowerData  = 32'h0;

  typedef struct {
    logic        owner;
    logic [9:0]  addr;
    logic        write;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          cycles;
  } expT;

  expT sbQ[$];

  l2_port_arbiter #(.ADDR_LENGTH(10), .BLOCK_SIZE(32), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .write0(write0), .write1(write1),
    .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1),
    .rdata(rdata), .err(err), .owner(owner),
    .lower_enable(lower_enable), .lower_addr(lower_addr),
    .lower_write(lower_write), .lower_data_out(lower_data_out),
    .lower_fetchComplete(lower_fetchComplete), .lower_data_in(lower_data_in)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic pushExpect(input logic own, input logic [9:0] a, input logic wr,
                            input logic [31:0] wd, input logic [31:0] rd, input logic e, input int cyc);
    expT item;
    item.owner = own; item.addr = a; item.write = wr; item.wdata = wd;
    item.rdata = rd;  item.err = e;  item.cycles = cyc;
    sbQ.push_back(item);
  endtask

  // Raise one requester, hold it until its done pulse, then drop it on that cycle.
  task automatic applyStimulus(input logic port, input logic [9:0] a, input logic wr, input logic [31:0] wd);
    bit seen = 0;
    @(negedge clk);
    if (port) begin req1 = 1'b1; addr1 = a; write1 = wr; wdata1 = wd; end
    else      begin req0 = 1'b1; addr0 = a; write0 = wr; wdata0 = wd; end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((!port && done0) || (port && done1)) begin
        seen = 1;
        break;
      end
    end
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL doneTimeout: port %0d got no done, expected one within 200 cycles", port);
    end
  endtask

  // Scripted lower level: completes in the lowerDelay-th ISSUE cycle, never if negative.
  initial begin
    int issueCount = 0;
    lower_fetchComplete = 1'b0;
    lower_data_in       = 32'h0BAD0BAD;
    forever begin
      @(negedge clk);
      if (lower_enable) begin
        issueCount++;
        if (issueCount == lowerDelay) begin
          lower_fetchComplete = 1'b1;
          lower_data_in       = lowerData;
        end else begin
          lower_fetchComplete = 1'b0;
          lower_data_in       = 32'h0BAD0BAD;
        end
      end else begin
        issueCount          = 0;
        lower_fetchComplete = 1'b0;
        lower_data_in       = 32'h0BAD0BAD;
      end
    end
  end

  // Monitor: checks latched lower_* each ISSUE cycle, the enable gap, and each done pulse.
  initial begin
    int  run    = 0;
    int  lowGap = 0;
    bit  inTxn  = 0;
    bit  hadTxn = 0;
    expT item;
    forever begin
      @(negedge clk);
      if (lower_enable) begin
        if (!inTxn && hadTxn) begin
          vectors++;
          if (lowGap < 2) begin
            miscompares++;
            $display("[TB] FAIL enableGap: got %0d low cycles, expected at least 2", lowGap);
          end
        end
        inTxn  = 1;
        run++;
        lowGap = 0;
        if (sbQ.size() == 0) begin
          checkOutput("issueWithoutExpect", 32'(lower_enable), 32'h0);
        end else begin
          checkOutput("issueAddr",  32'(lower_addr),  32'(sbQ[0].addr));
          checkOutput("issueWrite", 32'(lower_write), 32'(sbQ[0].write));
          checkOutput("issueWdata", lower_data_out,   sbQ[0].wdata);
          checkOutput("issueOwner", 32'(owner),       32'(sbQ[0].owner));
        end
      end else begin
        lowGap++;
        if (done0 || done1) begin
          if (sbQ.size() == 0) begin
            checkOutput("unexpectedDone", {30'h0, done1, done0}, 32'h0);
          end else begin
            item = sbQ.pop_front();
            checkOutput("doneSelect",  {30'h0, done1, done0}, item.owner ? 32'h2 : 32'h1);
            checkOutput("doneOwner",   32'(owner),      32'(item.owner));
            checkOutput("doneRdata",   rdata,           item.rdata);
            checkOutput("doneErr",     32'(err),        32'(item.err));
            checkOutput("doneAddr",    32'(lower_addr), 32'(item.addr));
            checkOutput("issueCycles", 32'(run),        32'(item.cycles));
          end
          hadTxn = 1;
        end
        run   = 0;
        inTxn = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    addr0 = '0; addr1 = '0;
    write0 = 1'b0; write1 = 1'b0;
    wdata0 = '0; wdata1 = '0;

    // Reset with both requesting, then continuous contention alternating 0,1,0,1.
    lowerDelay = 2;
    lowerData  = 32'h13579BDF;
    pushExpect(1'b0, 10'h100, 1'b0, 32'h0, 32'h13579BDF, 1'b0, 2);
    pushExpect(1'b1, 10'h200, 1'b0, 32'h0, 32'h13579BDF, 1'b0, 2);
    pushExpect(1'b0, 10'h101, 1'b0, 32'h0, 32'h13579BDF, 1'b0, 2);
    pushExpect(1'b1, 10'h201, 1'b0, 32'h0, 32'h13579BDF, 1'b0, 2);
    fork
      begin
        applyStimulus(1'b0, 10'h100, 1'b0, 32'h0);
        applyStimulus(1'b0, 10'h101, 1'b0, 32'h0);
      end
      begin
        applyStimulus(1'b1, 10'h200, 1'b0, 32'h0);
        applyStimulus(1'b1, 10'h201, 1'b0, 32'h0);
      end
      begin
        repeat (3) @(negedge clk);
        checkOutput("rstEnable",   32'(lower_enable),   32'h0);
        checkOutput("rstDone",     {30'h0, done1, done0}, 32'h0);
        checkOutput("rstErr",      32'(err),            32'h0);
        checkOutput("rstRdata",    rdata,               32'h0);
        checkOutput("rstOwner",    32'(owner),          32'h0);
        checkOutput("rstAddr",     32'(lower_addr),     32'h0);
        checkOutput("rstWrite",    32'(lower_write),    32'h0);
        checkOutput("rstDataOut",  lower_data_out,      32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("firstGrantOwner",  32'(owner),        32'h0);
        checkOutput("firstGrantEnable", 32'(lower_enable), 32'h1);
      end
    join

    // Single read, completion in the third ISSUE cycle.
    lowerDelay = 3;
    lowerData  = 32'hDEADBEEF;
    pushExpect(1'b0, 10'h004, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    applyStimulus(1'b0, 10'h004, 1'b0, 32'h0);

    // Write from requester 1; the returned block is captured for writes too.
    lowerDelay = 2;
    lowerData  = 32'h12345678;
    pushExpect(1'b1, 10'h155, 1'b1, 32'hFFFFFFFF, 32'h12345678, 1'b0, 2);
    applyStimulus(1'b1, 10'h155, 1'b1, 32'hFFFFFFFF);

    // Lower level never answers: abort after 8 ISSUE cycles.
    lowerDelay = -1;
    pushExpect(1'b0, 10'h0AA, 1'b0, 32'h0, 32'h0, 1'b1, 8);
    applyStimulus(1'b0, 10'h0AA, 1'b0, 32'h0);

    // Completion on the very cycle the timeout would fire.
    lowerDelay = 8;
    lowerData  = 32'hCAFEF00D;
    pushExpect(1'b1, 10'h2C3, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, 8);
    applyStimulus(1'b1, 10'h2C3, 1'b0, 32'h0);

    // Minimum latency: completion in the first ISSUE cycle.
    lowerDelay = 1;
    lowerData  = 32'h00000001;
    pushExpect(1'b0, 10'h3FF, 1'b1, 32'hA5A5A5A5, 32'h00000001, 1'b0, 1);
    applyStimulus(1'b0, 10'h3FF, 1'b1, 32'hA5A5A5A5);

    // Reset in the middle of ISSUE; the still-pending req1 is re-granted afterwards.
    lowerDelay = -1;
    pushExpect(1'b1, 10'h321, 1'b0, 32'h0, 32'h55AA55AA, 1'b0, 2);
    fork
      applyStimulus(1'b1, 10'h321, 1'b0, 32'h0);
      begin
        bit seenEnable = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (lower_enable) begin
            seenEnable = 1;
            break;
          end
        end
        checkOutput("midIssueReached", 32'(seenEnable), 32'h1);
        @(negedge clk);
        reset      = 1'b0;
        lowerDelay = 2;
        lowerData  = 32'h55AA55AA;
        #1;
        checkOutput("asyncEnableDrop", 32'(lower_enable), 32'h0);
        checkOutput("asyncDoneLow",    {30'h0, done1, done0}, 32'h0);
        checkOutput("asyncOwnerClear", 32'(owner), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
      end
    join

    repeat (4) @(negedge clk);
    checkOutput("queueEmpty", 32'(sbQ.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
